// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared types and helpers for the word-to-lane stream serializer.
//   serializer_state_t : serializer FSM states
//   lane_idx_width()   : width of a lane index for a given lane count (min 1)
//   words_for_lanes()  : number of FIFO words needed to cover a lane count
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } serializer_state_t;

    function automatic int lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int words_for_lanes(input int lane_count, input int lanes);
        return (lane_count + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/ahb3lite_lane_select.sv
// ---------------------------------------------------------------------------
// ahb3lite_lane_select
// Combinational lane multiplexer: picks one LANE_W slice out of a DATA_W word.
// Little-endian order returns lane i_idx; big-endian order returns lane
// LANES-1-i_idx, so index 0 is always the first lane emitted.
// Ports:
//   i_word       in  DATA_W  word being serialized
//   i_idx        in  LIDX_W  lane position within the word
//   i_big_endian in  1       1 = most significant lane first
//   o_lane       out LANE_W  selected lane
// ---------------------------------------------------------------------------
module ahb3lite_lane_select
    import ahb3lite_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int LIDX_W = lane_idx_width(DATA_W / LANE_W)
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [LIDX_W-1:0] i_idx,
    input  logic              i_big_endian,
    output logic [LANE_W-1:0] o_lane
);

    localparam int LANES = DATA_W / LANE_W;

    logic [LANE_W-1:0] lanes [LANES];
    logic [LIDX_W-1:0] sel;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lanes[gi] = i_word[gi*LANE_W +: LANE_W];
        end
    endgenerate

    always_comb begin
        sel    = i_big_endian ? (LIDX_W'(LANES - 1) - i_idx) : i_idx;
        o_lane = '0;
        // Guards non-power-of-two lane counts where the index range exceeds LANES.
        if (int'(sel) < LANES) begin
            o_lane = lanes[sel];
        end
    end

endmodule

// File: rtl/ahb3lite_stream_serializer.sv
// ---------------------------------------------------------------------------
// ahb3lite_stream_serializer
// Pops DATA_W words from the DMA read FIFO and emits them as LANE_W lanes on a
// valid/ready stream, with selectable endianness, exact handling of a partial
// final word, downstream backpressure and abort. No prefetch: the next word is
// only requested after the last lane of the current word has been accepted.
// Ports:
//   HCLK, HRESET   clock, synchronous active-high reset
//   i_start        start pulse, accepted only while idle
//   i_lane_count   lanes to emit (sampled with i_start)
//   i_big_endian   lane order (sampled with i_start)
//   i_abort        cancel transfer, highest priority
//   i_fifo_empty   FIFO empty flag
//   i_fifo_dout    FIFO data, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en   FIFO pop pulse
//   o_data/o_valid/i_ready/o_last   output lane stream
//   o_lane_idx     lane position within the current word
//   o_lane_cnt     lanes accepted so far in this transfer
//   o_busy         not idle
//   o_done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module ahb3lite_stream_serializer
    import ahb3lite_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 16,
    parameter int LIDX_W = lane_idx_width(DATA_W / LANE_W)
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_lane_count,
    input  logic              i_big_endian,
    input  logic              i_abort,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_dout,
    output logic              o_fifo_rd_en,
    output logic [LANE_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic [LIDX_W-1:0] o_lane_idx,
    output logic [CNT_W-1:0]  o_lane_cnt,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                LANES    = DATA_W / LANE_W;
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(LANES - 1);

    serializer_state_t state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              big_endian_q, big_endian_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [LIDX_W-1:0] lane_idx_q, lane_idx_d;
    logic [CNT_W-1:0]  lane_cnt_q, lane_cnt_d;

    logic              final_lane;

    // The lane being presented is the last one of the transfer.
    assign final_lane = (lane_cnt_q == (count_q - CNT_W'(1)));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            big_endian_q <= 1'b0;
            word_q       <= '0;
            lane_idx_q   <= '0;
            lane_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            big_endian_q <= big_endian_d;
            word_q       <= word_d;
            lane_idx_q   <= lane_idx_d;
            lane_cnt_q   <= lane_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        big_endian_d = big_endian_q;
        word_d       = word_q;
        lane_idx_d   = lane_idx_q;
        lane_cnt_d   = lane_cnt_q;
        o_fifo_rd_en = 1'b0;
        o_done       = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            // A lane the consumer takes in the abort cycle still counts as accepted.
            if ((state_q == ST_SHIFT) && i_ready) begin
                lane_cnt_d = lane_cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        count_d      = i_lane_count;
                        big_endian_d = i_big_endian;
                        lane_cnt_d   = '0;
                        lane_idx_d   = '0;
                        state_d      = (i_lane_count == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!i_fifo_empty) begin
                        o_fifo_rd_en = 1'b1;
                        state_d      = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    word_d     = i_fifo_dout;
                    lane_idx_d = '0;
                    state_d    = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (i_ready) begin
                        lane_cnt_d = lane_cnt_q + CNT_W'(1);
                        lane_idx_d = lane_idx_q + LIDX_W'(1);
                        // Count reached ends the transfer even mid-word; leftover lanes drop.
                        if (final_lane) begin
                            state_d = ST_DONE;
                        end else if (lane_idx_q == LAST_IDX) begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    ahb3lite_lane_select #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .LIDX_W (LIDX_W)
    ) u_lane_select (
        .i_word       (word_q),
        .i_idx        (lane_idx_q),
        .i_big_endian (big_endian_q),
        .o_lane       (o_data)
    );

    assign o_valid    = (state_q == ST_SHIFT);
    assign o_last     = (state_q == ST_SHIFT) && final_lane;
    assign o_lane_idx = lane_idx_q;
    assign o_lane_cnt = lane_cnt_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb3lite_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_stream_serializer
// Self-checking bench: directed table of transfers, a few hand-written corner
// sequences (abort+start, mid-transfer reset) and randomized transfers checked
// against a lane-order reference model built from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ahb3lite_stream_serializer;

    localparam int DATA_W = 32;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 16;
    localparam int LANES  = DATA_W / LANE_W;
    localparam int LIDX_W = 2;
    localparam int BUDGET = 3000;

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b1;
    logic              i_start = 1'b0;
    logic [CNT_W-1:0]  i_lane_count = '0;
    logic              i_big_endian = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_fifo_empty = 1'b1;
    logic [DATA_W-1:0] i_fifo_dout = '0;
    logic              o_fifo_rd_en;
    logic [LANE_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic              o_last;
    logic [LIDX_W-1:0] o_lane_idx;
    logic [CNT_W-1:0]  o_lane_cnt;
    logic              o_busy;
    logic              o_done;

    ahb3lite_stream_serializer #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .i_start      (i_start),
        .i_lane_count (i_lane_count),
        .i_big_endian (i_big_endian),
        .i_abort      (i_abort),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_dout  (i_fifo_dout),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_lane_idx   (o_lane_idx),
        .o_lane_cnt   (o_lane_cnt),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;

    // FIFO model and per-transfer observations
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] pending_word;
    bit                pending_vld = 1'b0;
    logic [LANE_W-1:0] got[$];
    int cyc = 0;
    int pops, dones, n_last, last_pos, last_beat_cyc, done_cyc, start_cyc;
    int stall_errs, idx_errs, empty_pops;
    bit prev_stall = 1'b0;
    logic [LANE_W-1:0] prev_data;
    logic              prev_last;
    logic [LIDX_W-1:0] prev_idx;
    int ready_mode = 0;
    int gap_after = -1, gap_len = 0, gap_cnt = 0;
    int abort_at = -1, abort_cyc = 0;
    bit aborted = 1'b0, spam = 1'b0, start_req = 1'b0, force_abort = 1'b0;
    logic [CNT_W-1:0] start_count = '0;
    bit start_be = 1'b0;

    typedef struct {
        int          count;
        bit          be;
        int          mode;
        int          gap_after;
        int          gap_len;
        int          abort_at;
        logic [63:0] exp_bytes;
        int          exp_pops;
    } vec_t;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference lane order: lane i of the transfer comes from word i/LANES,
    // byte position i%LANES counted from the LS end (LE) or the MS end (BE).
    function automatic void build_expect(input logic [DATA_W-1:0] w[$], input int count,
                                         input bit be, output logic [LANE_W-1:0] e[$]);
        e.delete();
        for (int i = 0; i < count; i++) begin
            int pos   = i % LANES;
            int shamt = be ? (LANES - 1 - pos) : pos;
            e.push_back(LANE_W'(w[i / LANES] >> (shamt * LANE_W)));
        end
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step();
        bit forced;
        @(negedge HCLK);
        if (pending_vld) begin
            i_fifo_dout = pending_word;
            pending_vld = 1'b0;
        end
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ((cyc % 3) == 0);
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
        i_abort = force_abort;
        if (abort_at >= 0 && !aborted && got.size() == abort_at) begin
            i_abort   = 1'b1;
            i_ready   = 1'b0;
            aborted   = 1'b1;
            abort_cyc = cyc;
        end
        i_start = 1'b0;
        if (start_req) begin
            i_start      = 1'b1;
            i_lane_count = start_count;
            i_big_endian = start_be;
            start_req    = 1'b0;
            start_cyc    = cyc;
        end else if (spam && dones == 0) begin
            i_start      = 1'($urandom_range(0, 1));
            i_lane_count = CNT_W'($urandom);
            i_big_endian = 1'($urandom_range(0, 1));
        end
        forced = (gap_after >= 0 && pops == gap_after && gap_cnt < gap_len);
        if (forced) gap_cnt++;
        i_fifo_empty = forced || (fifo_q.size() == 0);
        #1;
        if (o_fifo_rd_en) begin
            pops++;
            if (i_fifo_empty) begin
                empty_pops++;
            end else begin
                pending_word = fifo_q.pop_front();
                pending_vld  = 1'b1;
            end
        end
        if (o_done) begin
            dones++;
            done_cyc = cyc;
        end
        if (o_valid && prev_stall &&
            (o_data !== prev_data || o_last !== prev_last || o_lane_idx !== prev_idx)) begin
            stall_errs++;
        end
        if (o_valid && i_ready) begin
            if (o_lane_idx !== LIDX_W'(got.size() % LANES)) idx_errs++;
            if (o_last) begin
                n_last++;
                last_pos = got.size();
            end
            got.push_back(o_data);
            last_beat_cyc = cyc;
        end
        prev_stall = o_valid && !i_ready;
        prev_data  = o_data;
        prev_last  = o_last;
        prev_idx   = o_lane_idx;
        cyc++;
    endtask

    task automatic clear_obs();
        got.delete();
        pops = 0; dones = 0; n_last = 0; last_pos = -1;
        last_beat_cyc = -1; done_cyc = -1; start_cyc = -1;
        stall_errs = 0; idx_errs = 0; empty_pops = 0; prev_stall = 1'b0;
        gap_cnt = 0; aborted = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input int count, input bit be, input int mode,
                            input int g_after, input int g_len, input int ab_at, input bit spm,
                            input logic [LANE_W-1:0] exp[$], input int exp_pops);
        bit finished;
        int exp_cnt;
        finished = 1'b0;
        clear_obs();
        ready_mode  = mode;
        gap_after   = g_after;
        gap_len     = g_len;
        abort_at    = ab_at;
        spam        = spm;
        start_count = CNT_W'(count);
        start_be    = be;
        start_req   = 1'b1;
        for (int k = 0; k < BUDGET && !finished; k++) begin
            step();
            if (dones > 0) finished = 1'b1;
            if (aborted && (cyc - abort_cyc) == 2) check({tag, "_abort_idle"}, o_busy, 0);
            if (aborted && (cyc - abort_cyc) >= 5) finished = 1'b1;
        end
        spam = 1'b0;
        abort_at = -1;
        gap_after = -1;
        check({tag, "_finished"}, finished, 1);
        check({tag, "_beats"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_lane%0d", tag, i), got[i], exp[i]);
        end
        check({tag, "_stall_hold"}, stall_errs, 0);
        check({tag, "_lane_idx"}, idx_errs, 0);
        check({tag, "_pop_when_empty"}, empty_pops, 0);
        if (ab_at >= 0) begin
            check({tag, "_done_pulses"}, dones, 0);
            check({tag, "_last_flags"}, n_last, 0);
            exp_cnt = ab_at;
        end else begin
            check({tag, "_done_pulses"}, dones, 1);
            exp_cnt = count;
            if (count > 0) begin
                check({tag, "_last_flags"}, n_last, 1);
                check({tag, "_last_pos"}, last_pos, count - 1);
                check({tag, "_done_latency"}, done_cyc - last_beat_cyc, 1);
            end else begin
                check({tag, "_done_latency"}, done_cyc - start_cyc, 1);
            end
        end
        ready_mode = 0;
        step();
        check({tag, "_pops"}, pops, exp_pops);
        check({tag, "_idle_busy"}, o_busy, 0);
        check({tag, "_idle_valid"}, o_valid, 0);
        check({tag, "_final_cnt"}, o_lane_cnt, exp_cnt);
        fifo_q.delete();
        $display("xfer %s: count=%0d be=%0d beats=%0d pops=%0d done=%0d", tag, count, be,
                 got.size(), pops, dones);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              vecs[8];
        logic [LANE_W-1:0] e[$];
        logic [DATA_W-1:0] w[$];
        logic [63:0]       eb;
        logic [CNT_W-1:0]  held_cnt;
        int                nbeats, cnt, nw, ga, gl;
        bit                be;

        vecs[0] = '{8, 1'b0, 0, -1, 0,  -1, 64'h8877665544332211, 2};
        vecs[1] = '{8, 1'b1, 0, -1, 0,  -1, 64'h5566778811223344, 2};
        vecs[2] = '{5, 1'b0, 0, -1, 0,  -1, 64'h0000005544332211, 2};
        vecs[3] = '{8, 1'b0, 1, -1, 0,  -1, 64'h8877665544332211, 2};
        vecs[4] = '{8, 1'b0, 0,  1, 10, -1, 64'h8877665544332211, 2};
        vecs[5] = '{8, 1'b0, 0, -1, 0,   3, 64'h0000000000332211, 1};
        vecs[6] = '{0, 1'b0, 0, -1, 0,  -1, 64'h0000000000000000, 0};
        vecs[7] = '{6, 1'b1, 1, -1, 0,  -1, 64'h0000778811223344, 2};

        // Reset state
        HRESET = 1'b1;
        repeat (3) step();
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_rd_en", o_fifo_rd_en, 0);
        check("rst_data", o_data, 0);
        check("rst_last", o_last, 0);
        check("rst_lane_idx", o_lane_idx, 0);
        check("rst_lane_cnt", o_lane_cnt, 0);
        HRESET = 1'b0;
        step();
        check("post_rst_busy", o_busy, 0);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            fifo_q = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
            eb     = vecs[v].exp_bytes;
            nbeats = (vecs[v].abort_at >= 0) ? vecs[v].abort_at : vecs[v].count;
            e.delete();
            for (int i = 0; i < nbeats; i++) e.push_back(eb[i*LANE_W +: LANE_W]);
            run_xfer($sformatf("vec%0d", v), vecs[v].count, vecs[v].be, vecs[v].mode,
                     vecs[v].gap_after, vecs[v].gap_len, vecs[v].abort_at, 1'b0, e,
                     vecs[v].exp_pops);
        end

        // Abort and start together while idle: abort wins, nothing starts.
        clear_obs();
        held_cnt    = o_lane_cnt;
        fifo_q      = '{32'h44332211};
        force_abort = 1'b1;
        start_count = CNT_W'(4);
        start_be    = 1'b0;
        start_req   = 1'b1;
        step();
        force_abort = 1'b0;
        step();
        step();
        check("abort_start_busy", o_busy, 0);
        check("abort_start_pops", pops, 0);
        check("abort_start_cnt_held", o_lane_cnt, held_cnt);
        fifo_q.delete();
        $display("xfer abort_start: busy=%0d pops=%0d", o_busy, pops);

        // Reset in the middle of a transfer returns everything to reset values.
        clear_obs();
        fifo_q      = '{32'h44332211, 32'h88776655};
        start_count = CNT_W'(8);
        start_req   = 1'b1;
        repeat (6) step();
        check("midrst_running", o_busy, 1);
        HRESET = 1'b1;
        step();
        check("midrst_busy", o_busy, 0);
        check("midrst_valid", o_valid, 0);
        check("midrst_cnt", o_lane_cnt, 0);
        check("midrst_idx", o_lane_idx, 0);
        check("midrst_data", o_data, 0);
        HRESET = 1'b0;
        fifo_q.delete();
        pending_vld = 1'b0;
        step();
        $display("xfer midrst: beats_before_reset=%0d", got.size());

        // Randomized transfers against the reference model
        for (int t = 0; t < 12; t++) begin
            cnt = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 23));
            be  = 1'($urandom_range(0, 1));
            nw  = (cnt + LANES - 1) / LANES;
            w.delete();
            for (int i = 0; i <= nw; i++) w.push_back($urandom);
            fifo_q = w;
            build_expect(w, cnt, be, e);
            ga = int'($urandom_range(0, nw));
            gl = int'($urandom_range(0, 6));
            run_xfer($sformatf("rnd%0d", t), cnt, be, 2, ga, gl, -1, 1'b1, e, nw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
